// File: rtl/tetris_pkg.sv
// Shared constants for the LED Tetris front end and the downstream LED block.
package tetris_pkg;

    localparam int unsigned NUM_BTN   = 4;
    localparam int unsigned BTN_RIGHT = 0;
    localparam int unsigned BTN_ROT_B = 1;
    localparam int unsigned BTN_ROT_F = 2;
    localparam int unsigned BTN_LEFT  = 3;

    // Only the shift buttons auto-repeat by default.
    localparam logic [NUM_BTN-1:0] REPEAT_MASK_DEFAULT = 4'b1001;

    function automatic logic [NUM_BTN-1:0] lowest_one(input logic [NUM_BTN-1:0] v);
        return v & (~v + 4'd1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-bit 2-flop synchroniser plus counter-based debouncer.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            s1_q, s2_q;
    logic            state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (s2_q != state_q) begin
            // Flip on the edge the count would reach DEBOUNCE_CYCLES.
            if (cnt_q == CntLast) begin
                state_d = ~state_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn_raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces four buttons and issues single-cycle one-hot command pulses with auto-repeat.
module button_conditioner
    import tetris_pkg::*;
#(
    parameter int unsigned        DEBOUNCE_CYCLES = 4,
    parameter int unsigned        REPEAT_DELAY    = 50,
    parameter int unsigned        REPEAT_PERIOD   = 20,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = REPEAT_MASK_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] button,
    output logic [NUM_BTN-1:0] btn_level
);

    localparam int unsigned TmrMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);
    localparam logic [TmrW-1:0] DelayV  = TmrW'(REPEAT_DELAY);
    localparam logic [TmrW-1:0] PeriodV = TmrW'(REPEAT_PERIOD);
    localparam logic [NUM_BTN-1:0] RepEn = (REPEAT_DELAY != 0) ? REPEAT_MASK : '0;

    logic [NUM_BTN-1:0]           level, level_q, rise, rep_req, grant;
    logic [NUM_BTN-1:0]           pending_q, pending_d, button_q;
    logic [NUM_BTN-1:0][TmrW-1:0] tmr_q, tmr_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn_raw[i]),
            .level  (level[i])
        );
    end

    assign rise = level & ~level_q;

    // Timer value 0 is idle; a request fires in the cycle the timer reads 1.
    always_comb begin
        tmr_d   = tmr_q;
        rep_req = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (!RepEn[i] || !level[i]) begin
                tmr_d[i] = '0;
            end else if (rise[i]) begin
                tmr_d[i] = DelayV;
            end else if (tmr_q[i] == TmrW'(1)) begin
                rep_req[i] = 1'b1;
                tmr_d[i]   = PeriodV;
            end else if (tmr_q[i] != '0) begin
                tmr_d[i] = tmr_q[i] - TmrW'(1);
            end
        end
    end

    // New requests are OR-ed in after the grant clears, so set wins over clear.
    assign grant     = lowest_one(pending_q);
    assign pending_d = (pending_q & ~grant) | rise | rep_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= '0;
            tmr_q     <= '0;
            pending_q <= '0;
            button_q  <= '0;
        end else begin
            level_q   <= level;
            tmr_q     <= tmr_d;
            pending_q <= pending_d;
            button_q  <= grant;
        end
    end

    assign button    = button_q;
    assign btn_level = level;

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end input stage for the LED Tetris board. It takes the four raw push-button pins, synchronises and debounces each one, and turns presses into single-cycle one-hot command pulses. Held shift buttons also produce auto-repeat pulses. Its `button` output drives the `button` input of the LED block directly downstream. That block acts on every cycle in which `button` is exactly one-hot, so this stage must never present a multi-hot or held value.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronised input must differ from the debounced state before that state flips; legal range ≥1.
- `REPEAT_DELAY`, default 50: cycles from a press event to the first auto-repeat; 0 disables auto-repeat.
- `REPEAT_PERIOD`, default 20: cycles between subsequent auto-repeats; legal range ≥1.
- `REPEAT_MASK`, default 4'b1001: buttons eligible for auto-repeat (the shift buttons).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  4  raw active-high button pins, asynchronous to `clk`.
- `button`  out  4  registered one-hot command pulse, or 4'b0000.
- `btn_level`  out  4  debounced level of each button, for status/debug.

## Operation
- Reset (asserted asynchronously, any time including mid-operation) clears all of the following to 0: synchroniser flops, debounce counters, debounced state, repeat timers, the pending register, `button` and `btn_level`. Outputs read 0 immediately.
- Per bit, the synchroniser is two flops, `s1` then `s2`.
- Per bit, the debounce counter increments on each edge where `s2` ≠ debounced state.
  - It clears to 0 on any edge where they are equal; a bounce restarts the count.
  - The debounced state flips on the edge where the counter would reach `DEBOUNCE_CYCLES`; the counter clears on that same edge.
- Press event: a debounced 0→1 transition. On the next edge it sets that bit in `pending[3:0]`. Release (1→0) produces no pulse.
- Auto-repeat, applies only to bits in `REPEAT_MASK` and only when `REPEAT_DELAY` ≠ 0:
  - The per-bit timer starts at the press event.
  - A pending set occurs `REPEAT_DELAY` cycles after the press event, then every `REPEAT_PERIOD` cycles while the debounced level stays 1.
  - Release clears the timer at once; a repeat falling due on the release edge is suppressed.
- Issue: each edge, if `pending` ≠ 0, `button` takes the lowest-indexed set bit as a one-hot value and that bit clears; otherwise `button` ← 0.
- A set request for a bit that is already pending merges into it and does not queue twice.
- A set request and a clear of the same bit on the same edge: set wins, so a new request is never lost.
- Counter and timer widths are `$clog2` of the largest value they must hold. No wrap is permitted before the terminal count.

## Timing
- Raw rise first sampled at edge 0:
  - `s2` = 1 after edge 1;
  - debounced flip at edge 1+D (D = `DEBOUNCE_CYCLES`);
  - pending set at edge 2+D;
  - `button` one-hot from edge 3+D for exactly one cycle.
- End-to-end latency is D+3 cycles.
- Simultaneous presses: issued on consecutive cycles in index order 0,1,2,3, with no idle cycles between them.
- Pulse width is always exactly 1 cycle. The issue rate is at most one pulse per cycle.
- `btn_level` equals the debounced state, with no extra delay.

## Structure
- Shared package `tetris_pkg`: button index constants `BTN_RIGHT`=0, `BTN_ROT_B`=1, `BTN_ROT_F`=2, `BTN_LEFT`=3, and the default `REPEAT_MASK` value. The downstream LED block uses the same constants.
- Sub-module `btn_debounce`: 2-flop synchroniser, debounce counter and debounced state for a single bit, parameterised by `DEBOUNCE_CYCLES`. It is instantiated four times.
- The top level holds the repeat timers, the `pending` register and the priority issue logic.

## Test plan
- Clean press of bit 0 with D=4, held 100 cycles, `REPEAT_MASK`=0 -> `button`=4'b0001 for exactly one cycle, 7 cycles after the first sample edge; `button`=0 at all other times.
- Bounce: `btn_raw[2]` toggles 1,0,1,0 on alternate cycles, then held at 1 -> single 4'b0100 pulse, D+3 cycles after the last 0→1 toggle.
- Bits 1 and 3 rise on the same edge -> 4'b0010 then 4'b1000 on consecutive cycles, never 4'b1010.
- Bit 3 held with `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5 -> pulses at press+0, +10, +15, +20… (press-event relative); bit 1 held the same way gives one pulse only.
- `rst_n` asserted low while bit 0 is pending and bit 3 is mid-debounce -> `button`, `btn_level` and `pending` read 0 asynchronously. No pulse appears after release until a fresh D+3 press sequence completes.
